// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared defaults and the round-robin pick helper for the write-back scheduler
package rf_wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int MAX_REQ    = 8;

    // One-hot grant: first valid requester at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [2:0]         idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && !found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rf_wb_scheduler_arb.sv
// rr_arbiter: combinational round-robin arbiter, req/ptr in, one-hot grant out
module rr_arbiter
    import rf_wb_pkg::*;
#(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [MAX_REQ-1:0] g;

    assign g     = rr_pick(MAX_REQ'(req), 3'(ptr), N);
    assign grant = g[N-1:0];

    generate
        if (N < MAX_REQ) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^g[MAX_REQ-1:N];
        end
    endgenerate

endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: round-robin write-back arbiter, registered RF write port and busy scoreboard
// Ports: clk/reset (sync, active-low); issue_* in, stall out (decode side);
// req_valid/req_rd/req_data in, req_ready out (requesters); wr_enab/wr_addr/wr_data out (RF);
// busy_vec out (pending writes). Optional macro RF_WB_FORWARD_EN: a retiring register does not stall.
module rf_wb_scheduler
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [REG_AW-1:0]         issue_rs1,
    input  logic [REG_AW-1:0]         issue_rs2,
    output logic                      stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_enab,
    output logic [REG_AW-1:0]         wr_addr,
    output logic [XLEN-1:0]           wr_data,
    output logic [2**REG_AW-1:0]      busy_vec
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int NREG = 2**REG_AW;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gidx;
    logic [NUM_REQ-1:0] grant;
    logic              hs;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [NREG-1:0]   retire;
    logic [NREG-1:0]   live;
    logic [NREG-1:0]   busy_nxt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready = reset ? grant : '0;
    assign hs        = |req_ready;

    always_comb begin
        gidx     = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx     = PW'(i);
                sel_rd   = req_rd[i*REG_AW +: REG_AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr  <= '0;
            wr_enab <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_enab <= hs && sel_rd != '0;
            if (hs) begin
                rr_ptr  <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end
        end
    end

`ifdef RF_WB_FORWARD_EN
    assign retire = wr_enab ? NREG'(1) << wr_addr : '0;
`else
    assign retire = '0;
`endif

    // x0 is masked so a hazard lookup on register 0 never stalls.
    assign live  = busy_vec & ~retire & ~NREG'(1);
    assign stall = reset & issue_valid & (live[issue_rs1] | live[issue_rs2] | live[issue_rd]);

    // Clear before set so a same-cycle re-issue of a retiring register stays busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_enab) busy_nxt[wr_addr] = 1'b0;
        if (issue_valid && !stall && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) busy_vec <= '0;
        else        busy_vec <= busy_nxt;
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: randomized scoreboard bench for rf_wb_scheduler against a rule-level model
module tb_rf_wb_scheduler;

    localparam int N = 3;
`ifdef RF_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [4:0]    issue_rd, issue_rs1, issue_rs2;
    logic          stall;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0]  req_rd;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          wr_enab;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   busy_vec;

    rf_wb_scheduler #(.NUM_REQ(N), .XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .stall(stall),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .wr_enab(wr_enab), .wr_addr(wr_addr), .wr_data(wr_data), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {bit en; bit [4:0] addr; bit [31:0] data;} wr_t;
    wr_t q[$];

    int total = 0;
    int bad = 0;

    bit [4:0]  rrd[N];
    bit [31:0] rdat[N];

    int        m_ptr;
    bit        m_busy[32];
    bit        m_en;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit        m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hz(input bit [4:0] r);
        return r != 0 && m_busy[r] && !(FWD && m_en && m_addr == r);
    endfunction

    task automatic step(input bit rst_n, input bit iv, input bit [4:0] rd, input bit [4:0] rs1,
                        input bit [4:0] rs2, input bit [N-1:0] rv);
        int g;
        bit xs;
        bit [31:0] eb;
        wr_t e;
        @(negedge clk);
        reset = rst_n; issue_valid = iv; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
        req_valid = rv;
        for (int i = 0; i < N; i++) begin
            req_rd[i*5 +: 5]    = rrd[i];
            req_data[i*32 +: 32] = rdat[i];
        end
        #1;
        if (m_known) begin
            for (int r = 0; r < 32; r++) eb[r] = m_busy[r];
            chk("busy_vec", busy_vec, eb);
        end
        if (!rst_n) begin
            chk("req_ready", 32'(req_ready), 0);
            chk("stall", 32'(stall), 0);
            m_ptr = 0;
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            m_en = 1'b0; m_addr = '0; m_data = '0; m_known = 1'b1;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            chk("req_ready", 32'(req_ready), g < 0 ? 0 : 32'(1) << g);
            xs = iv && (hz(rs1) || hz(rs2) || (rd != 0 && hz(rd)));
            chk("stall", 32'(stall), 32'(xs));
            if (m_en) m_busy[m_addr] = 1'b0;
            if (iv && !xs && rd != 0) m_busy[rd] = 1'b1;
            if (g >= 0) begin
                m_en = rrd[g] != 0; m_addr = rrd[g]; m_data = rdat[g];
                m_ptr = (g + 1) % N;
            end else m_en = 1'b0;
        end
        e.en = m_en; e.addr = m_addr; e.data = m_data;
        q.push_back(e);
    endtask

    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_enab", 32'(wr_enab), 32'(e.en));
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        reset = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        req_valid = '0; req_rd = '0; req_data = '0;
        rrd[0] = 5; rrd[1] = 6; rrd[2] = 7;
        rdat[0] = 32'hA; rdat[1] = 32'hB; rdat[2] = 32'hC;
        repeat (2) step(0, 0, 0, 0, 0, 3'b111);
        repeat (6) step(1, 0, 0, 0, 0, 3'b111);
        step(1, 0, 0, 0, 0, 3'b000);
        step(1, 1, 5, 0, 0, 3'b000);
        repeat (2) step(1, 1, 0, 5, 0, 3'b000);
        rrd[0] = 5; rdat[0] = 32'h55;
        step(1, 1, 0, 5, 0, 3'b001);
        repeat (3) step(1, 1, 0, 5, 0, 3'b000);
        rrd[0] = 0; rdat[0] = 32'hFFFF_FFFF;
        step(1, 1, 0, 1, 2, 3'b001);
        step(1, 0, 0, 0, 0, 3'b000);
        step(1, 1, 3, 0, 0, 3'b000);
        repeat (2) step(1, 1, 3, 0, 0, 3'b000);
        rrd[1] = 3; rdat[1] = 32'h33;
        step(1, 1, 3, 0, 0, 3'b010);
        repeat (3) step(1, 1, 3, 0, 0, 3'b000);
        step(1, 1, 9, 0, 0, 3'b000);
        rrd[2] = 9; rdat[2] = 32'h99;
        step(1, 0, 0, 0, 0, 3'b100);
        step(1, 1, 9, 0, 9, 3'b000);
        repeat (2) step(1, 0, 0, 0, 0, 3'b000);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                rrd[i]  = 5'($urandom_range(0, 7));
                rdat[i] = $urandom;
            end
            step($urandom_range(0, 99) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom));
        end
        repeat (2) step(1, 0, 0, 0, 0, 3'b000);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
